// File: rtl/cache_arbiter.sv
// cache_arbiter: shares one physical-memory port between the I-cache miss port
// (A) and the D-cache miss port (B). One requester is served at a time; its
// strobes, address and wdata pass straight through to pmem, and pmem_resp is
// routed back to the served side only. A mandatory DONE cycle follows every
// completion so a requester's still-held request is never granted twice.
//
// Configuration macro ARBITER_RR_EN:
//   defined   - round-robin on ties (grant the side that was not served last)
//   undefined - fixed priority, B (data side) wins ties
//
// cache_arbiter_checker (same file) carries the simulation-only assertions.

module cache_arbiter #(
    parameter int LINE_WIDTH = 256,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  a_read,
    input  logic                  a_write,
    input  logic [ADDR_WIDTH-1:0] a_address,
    input  logic [LINE_WIDTH-1:0] a_wdata,
    output logic                  a_resp,
    output logic [LINE_WIDTH-1:0] a_rdata,
    input  logic                  b_read,
    input  logic                  b_write,
    input  logic [ADDR_WIDTH-1:0] b_address,
    input  logic [LINE_WIDTH-1:0] b_wdata,
    output logic                  b_resp,
    output logic [LINE_WIDTH-1:0] b_rdata,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic                  pmem_resp,
    input  logic [LINE_WIDTH-1:0] pmem_rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_A = 2'd1,
        SERVE_B = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t state_r;
    state_t state_s;
    // last_grant: 1'b0 = A served last, 1'b1 = B served last
    logic   last_grant_r;
    logic   last_grant_s;
    logic   req_a_s;
    logic   req_b_s;
    logic   grant_b_s;

    // Request decode and tie-break between the two miss ports
    always_comb begin
        req_a_s   = a_read | a_write;
        req_b_s   = b_read | b_write;
        grant_b_s = 1'b0;
`ifdef ARBITER_RR_EN
        if (req_a_s && req_b_s) begin
            grant_b_s = ~last_grant_r;
        end else begin
            grant_b_s = req_b_s;
        end
`else
        grant_b_s = req_b_s;
`endif
    end

    // Next-state and last-grant update
    always_comb begin
        state_s      = state_r;
        last_grant_s = last_grant_r;
        case (state_r)
            IDLE: begin
                if (req_a_s || req_b_s) begin
                    state_s = grant_b_s ? SERVE_B : SERVE_A;
                end else begin
                    state_s = IDLE;
                end
            end
            // A requester dropping its request early is a protocol error; we
            // keep serving until pmem completes rather than abandon pmem mid-op.
            SERVE_A: begin
                if (pmem_resp) begin
                    state_s      = DONE;
                    last_grant_s = 1'b0;
                end else begin
                    state_s = SERVE_A;
                end
            end
            SERVE_B: begin
                if (pmem_resp) begin
                    state_s      = DONE;
                    last_grant_s = 1'b1;
                end else begin
                    state_s = SERVE_B;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register; reset abandons any in-flight downstream transaction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            last_grant_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            last_grant_r <= last_grant_s;
        end
    end

    // Steer the served side onto pmem and route completion back to it
    always_comb begin
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = {ADDR_WIDTH{1'b0}};
        pmem_wdata   = {LINE_WIDTH{1'b0}};
        a_resp       = 1'b0;
        b_resp       = 1'b0;
        case (state_r)
            SERVE_A: begin
                pmem_read    = a_read;
                pmem_write   = a_write;
                pmem_address = a_address;
                pmem_wdata   = a_wdata;
                a_resp       = pmem_resp;
            end
            SERVE_B: begin
                pmem_read    = b_read;
                pmem_write   = b_write;
                pmem_address = b_address;
                pmem_wdata   = b_wdata;
                b_resp       = pmem_resp;
            end
            default: begin
                pmem_read = 1'b0;
            end
        endcase
    end

    // Read data is broadcast; only meaningful alongside the matching resp
    assign a_rdata = pmem_rdata;
    assign b_rdata = pmem_rdata;

`ifndef SYNTHESIS
    cache_arbiter_checker u_checker (
        .clk          (clk),
        .reset        (reset),
        .a_read       (a_read),
        .a_write      (a_write),
        .b_read       (b_read),
        .b_write      (b_write),
        .serve_a      (state_r == SERVE_A),
        .serve_b      (state_r == SERVE_B),
        .pmem_resp    (pmem_resp),
        .last_grant_b (last_grant_r)
    );
`endif

endmodule

// Simulation-only protocol checks for cache_arbiter.
module cache_arbiter_checker (
    input logic clk,
    input logic reset,
    input logic a_read,
    input logic a_write,
    input logic b_read,
    input logic b_write,
    input logic serve_a,
    input logic serve_b,
    input logic pmem_resp,
    input logic last_grant_b
);

    // A side must never read and write in the same cycle
    a_rw_exclusive: assert property (@(posedge clk) disable iff (reset)
        !(a_read && a_write));

    // B side must never read and write in the same cycle
    b_rw_exclusive: assert property (@(posedge clk) disable iff (reset)
        !(b_read && b_write));

    // Completion of A must record A as last served
    a_last_grant: assert property (@(posedge clk) disable iff (reset)
        (serve_a && pmem_resp) |=> !last_grant_b);

    // Completion of B must record B as last served
    b_last_grant: assert property (@(posedge clk) disable iff (reset)
        (serve_b && pmem_resp) |=> last_grant_b);

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter. A behavioural model decides which
// side should win each grant (fixed priority, or round-robin when
// ARBITER_RR_EN is defined) and the bench plays the pmem responder.
module tb_cache_arbiter;

    localparam int LW = 256;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          a_read = 1'b0, a_write = 1'b0;
    logic [AW-1:0] a_address = '0;
    logic [LW-1:0] a_wdata = '0;
    logic          a_resp;
    logic [LW-1:0] a_rdata;
    logic          b_read = 1'b0, b_write = 1'b0;
    logic [AW-1:0] b_address = '0;
    logic [LW-1:0] b_wdata = '0;
    logic          b_resp;
    logic [LW-1:0] b_rdata;
    logic          pmem_read, pmem_write;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic          pmem_resp = 1'b0;
    logic [LW-1:0] pmem_rdata = '0;

    int checks = 0;
    int failures = 0;
    logic last_b;   // model: 1 when B was the last side served

    cache_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset),
        .a_read(a_read), .a_write(a_write), .a_address(a_address), .a_wdata(a_wdata),
        .a_resp(a_resp), .a_rdata(a_rdata),
        .b_read(b_read), .b_write(b_write), .b_address(b_address), .b_wdata(b_wdata),
        .b_resp(b_resp), .b_rdata(b_rdata),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Arbitration rule: lone requester wins; ties go to B (fixed) or to the
    // side not served last (round-robin).
    function automatic logic model_pick_b(input logic ra, input logic rb, input logic lb);
`ifdef ARBITER_RR_EN
        if (ra && rb) return !lb;
`endif
        return rb;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        a_read = 1'b0; a_write = 1'b0; b_read = 1'b0; b_write = 1'b0;
        pmem_resp = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        last_b = 1'b0;
    endtask

    task automatic load_a(input logic en);
        logic op;
        op = 1'($urandom_range(0, 1));
        a_read = en & op; a_write = en & ~op;
        a_address = $urandom; a_wdata = rand_line();
    endtask

    task automatic load_b(input logic en);
        logic op;
        op = 1'($urandom_range(0, 1));
        b_read = en & op; b_write = en & ~op;
        b_address = $urandom; b_wdata = rand_line();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        a_read = 1'b1; b_write = 1'b1; pmem_resp = 1'b1;
        @(negedge clk);
        checks++;
        if ({pmem_read, pmem_write, a_resp, b_resp} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_strobes: got rd=%b wr=%b a_resp=%b b_resp=%b, want all 0",
                     pmem_read, pmem_write, a_resp, b_resp);
        end
        checks++;
        if (pmem_address !== '0 || pmem_wdata !== '0) begin
            failures++;
            $display("FAIL reset_addr_data: got addr=%h wdata=%h, want 0", pmem_address, pmem_wdata);
        end
        do_reset();
    endtask

    task automatic test_a_read();
        logic [LW-1:0] rd;
        do_reset();
        a_read = 1'b1; a_address = 32'h0000_0040; a_wdata = rand_line();
        @(negedge clk);
        checks++;
        if (pmem_read !== 1'b1 || pmem_write !== 1'b0 || pmem_address !== 32'h0000_0040) begin
            failures++;
            $display("FAIL a_read_strobe: got rd=%b wr=%b addr=%h, want 1 0 00000040",
                     pmem_read, pmem_write, pmem_address);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (a_resp !== 1'b0 || pmem_read !== 1'b1) begin
            failures++;
            $display("FAIL a_read_wait: got a_resp=%b rd=%b, want 0 1", a_resp, pmem_read);
        end
        rd = rand_line();
        pmem_rdata = rd; pmem_resp = 1'b1;
        #1;
        checks++;
        if (a_resp !== 1'b1 || b_resp !== 1'b0 || a_rdata !== rd) begin
            failures++;
            $display("FAIL a_read_resp: got a_resp=%b b_resp=%b a_rdata=%h, want 1 0 %h",
                     a_resp, b_resp, a_rdata, rd);
        end
        @(negedge clk);
        pmem_resp = 1'b0; a_read = 1'b0;
        #1;
        checks++;
        if ({pmem_read, pmem_write, a_resp, b_resp} !== 4'b0000) begin
            failures++;
            $display("FAIL a_read_done: got rd=%b wr=%b a_resp=%b b_resp=%b, want 0",
                     pmem_read, pmem_write, a_resp, b_resp);
        end
    endtask

    task automatic test_b_write();
        logic [LW-1:0] ones;
        ones = {LW{1'b1}};
        do_reset();
        b_write = 1'b1; b_address = 32'h8000_0100; b_wdata = ones;
        @(negedge clk);
        checks++;
        if (pmem_write !== 1'b1 || pmem_read !== 1'b0 || pmem_address !== 32'h8000_0100
            || pmem_wdata !== ones) begin
            failures++;
            $display("FAIL b_write_strobe: got wr=%b rd=%b addr=%h wdata=%h, want 1 0 80000100 all-ones",
                     pmem_write, pmem_read, pmem_address, pmem_wdata);
        end
        @(negedge clk);
        pmem_resp = 1'b1;
        #1;
        checks++;
        if (b_resp !== 1'b1 || a_resp !== 1'b0) begin
            failures++;
            $display("FAIL b_write_resp: got b_resp=%b a_resp=%b, want 1 0", b_resp, a_resp);
        end
        @(negedge clk);
        pmem_resp = 1'b0; b_write = 1'b0;
    endtask

    task automatic test_reset_mid_serve();
        do_reset();
        a_read = 1'b1; a_address = 32'h0000_0040;
        @(negedge clk);
        checks++;
        if (pmem_read !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset_serve: got rd=%b, want 1", pmem_read);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({pmem_read, pmem_write, a_resp, b_resp} !== 4'b0000 || pmem_address !== '0) begin
            failures++;
            $display("FAIL mid_reset_drop: got rd=%b wr=%b a_resp=%b b_resp=%b addr=%h, want 0",
                     pmem_read, pmem_write, a_resp, b_resp, pmem_address);
        end
        @(negedge clk);
        reset = 1'b0; a_read = 1'b0; pmem_resp = 1'b1;
        #1;
        checks++;
        if (a_resp !== 1'b0 || b_resp !== 1'b0) begin
            failures++;
            $display("FAIL late_resp: got a_resp=%b b_resp=%b, want 0 0", a_resp, b_resp);
        end
        @(negedge clk);
        pmem_resp = 1'b0;
        checks++;
        if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
            failures++;
            $display("FAIL late_resp_idle: got rd=%b wr=%b, want 0 0", pmem_read, pmem_write);
        end
        last_b = 1'b0;
    endtask

    task automatic test_idle_resp();
        do_reset();
        pmem_resp = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({a_resp, b_resp, pmem_read, pmem_write} !== 4'b0000) begin
                failures++;
                $display("FAIL idle_resp cycle %0d: got a_resp=%b b_resp=%b rd=%b wr=%b, want 0",
                         i, a_resp, b_resp, pmem_read, pmem_write);
            end
        end
        pmem_resp = 1'b0;
    endtask

    task automatic test_drop_request();
        logic [AW-1:0] addr;
        do_reset();
        addr = $urandom;
        a_read = 1'b1; a_address = addr;
        @(negedge clk);
        a_read = 1'b0;                 // protocol error: drop before resp
        b_read = 1'b1; b_address = ~addr;
        @(negedge clk);
        checks++;
        if (pmem_read !== 1'b0 || pmem_address !== addr) begin
            failures++;
            $display("FAIL drop_stay_a: got rd=%b addr=%h, want 0 %h", pmem_read, pmem_address, addr);
        end
        pmem_resp = 1'b1;
        #1;
        checks++;
        if (a_resp !== 1'b1 || b_resp !== 1'b0) begin
            failures++;
            $display("FAIL drop_resp: got a_resp=%b b_resp=%b, want 1 0", a_resp, b_resp);
        end
        @(negedge clk);
        pmem_resp = 1'b0; b_read = 1'b0;
        @(negedge clk);
        last_b = 1'b0;
    endtask

    // n_a / n_b back-to-back transactions per side, requests held between them
    task automatic test_contention(input int n_a, input int n_b, input int max_dly);
        int a_left, b_left, waits, dly;
        logic exp_b, exp_rd, exp_wr;
        logic [AW-1:0] exp_addr;
        logic [LW-1:0] exp_wd, rd;
        bit first;
        a_left = n_a; b_left = n_b; first = 1'b1;
        do_reset();
        load_a(a_left > 0);
        load_b(b_left > 0);
        while (a_left + b_left > 0) begin
            exp_b    = model_pick_b(a_left > 0, b_left > 0, last_b);
            exp_rd   = exp_b ? b_read : a_read;
            exp_wr   = exp_b ? b_write : a_write;
            exp_addr = exp_b ? b_address : a_address;
            exp_wd   = exp_b ? b_wdata : a_wdata;
            waits = 0;
            do begin
                @(negedge clk);
                waits++;
            end while (!(pmem_read || pmem_write) && waits < 8);
            checks++;
            if (waits != (first ? 1 : 2)) begin
                failures++;
                $display("FAIL grant_latency: got %0d cycles, want %0d", waits, first ? 1 : 2);
            end
            first = 1'b0;
            checks++;
            if (pmem_read !== exp_rd || pmem_write !== exp_wr || pmem_address !== exp_addr
                || pmem_wdata !== exp_wd) begin
                failures++;
                $display("FAIL grant_side (want %s): got rd=%b wr=%b addr=%h, want rd=%b wr=%b addr=%h",
                         exp_b ? "B" : "A", pmem_read, pmem_write, pmem_address,
                         exp_rd, exp_wr, exp_addr);
            end
            dly = $urandom_range(0, max_dly);
            repeat (dly) @(negedge clk);
            checks++;
            if (a_resp !== 1'b0 || b_resp !== 1'b0 || pmem_address !== exp_addr) begin
                failures++;
                $display("FAIL serve_hold: got a_resp=%b b_resp=%b addr=%h, want 0 0 %h",
                         a_resp, b_resp, pmem_address, exp_addr);
            end
            rd = rand_line();
            pmem_rdata = rd; pmem_resp = 1'b1;
            #1;
            checks++;
            if (a_resp !== !exp_b || b_resp !== exp_b || (exp_b ? b_rdata : a_rdata) !== rd) begin
                failures++;
                $display("FAIL resp_route: got a_resp=%b b_resp=%b, want a_resp=%b b_resp=%b",
                         a_resp, b_resp, !exp_b, exp_b);
            end
            @(negedge clk);
            pmem_resp = 1'b0;
            #1;
            checks++;
            if ({pmem_read, pmem_write, a_resp, b_resp} !== 4'b0000) begin
                failures++;
                $display("FAIL done_cycle: got rd=%b wr=%b a_resp=%b b_resp=%b, want 0",
                         pmem_read, pmem_write, a_resp, b_resp);
            end
            last_b = exp_b;
            if (exp_b) begin
                b_left--;
                load_b(b_left > 0);
            end else begin
                a_left--;
                load_a(a_left > 0);
            end
        end
        repeat (2) @(negedge clk);
        checks++;
        if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
            failures++;
            $display("FAIL quiet_after: got rd=%b wr=%b, want 0 0", pmem_read, pmem_write);
        end
    endtask

    initial begin
        last_b = 1'b0;
        test_reset();
        test_a_read();
        test_b_write();
        test_contention(1, 1, 3);
        test_contention(2, 2, 2);
        test_reset_mid_serve();
        test_idle_resp();
        test_drop_request();
        for (int k = 0; k < 8; k++) begin
            test_contention($urandom_range(0, 3), $urandom_range(1, 3), 4);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
